// File: rtl/qkv_tile_fetch_engine.sv
// Q/K/V weight BRAM tile read sequencer: strided address generation,
// latency-absorbing output FIFO and valid/ready stream with tile tags.
module qkv_tile_fetch_engine #(
   parameter int ADDR_WIDTH       = 16,
   parameter int DATA_WIDTH       = 256,
   parameter int NUM_CHANNELS     = 3,
   parameter int BASE_OFFSET      = 0,
   parameter int CH_STRIDE        = 12288,
   parameter int FETCHES_PER_TILE = 32,
   parameter int TILES_PER_MATRIX = 24,
   parameter int TILE_STRIDE      = 32,
   parameter int ROW_STRIDE       = 1,
   parameter int FIFO_DEPTH       = 4,
   localparam int CH_W   = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1,
   localparam int TILE_W = TILES_PER_MATRIX > 1 ? $clog2(TILES_PER_MATRIX) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CH_W-1:0]       ch_sel,
   input  logic [TILE_W-1:0]     tile_start,
   input  logic                  mode_all,
   input  logic                  abort,
   output logic                  bram_en,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   input  logic [DATA_WIDTH-1:0] bram_dout,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last_fetch,
   output logic                  out_last_tile,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int FETCH_W = FETCHES_PER_TILE > 1 ? $clog2(FETCHES_PER_TILE) : 1;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_OFFSET);
   localparam logic [ADDR_WIDTH-1:0] CH_A   = ADDR_WIDTH'(CH_STRIDE);
   localparam logic [ADDR_WIDTH-1:0] TILE_A = ADDR_WIDTH'(TILE_STRIDE);
   localparam logic [ADDR_WIDTH-1:0] ROW_A  = ADDR_WIDTH'(ROW_STRIDE);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [TILE_W-1:0]   tile_q, tile_d;
   logic [TILE_W-1:0]   last_tile_q, last_tile_d;
   logic [FETCH_W-1:0]  fetch_q, fetch_d;
   logic                infl_q;
   logic [1:0]          infl_tag_q;
   logic                err_q;
   logic [DATA_WIDTH+1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    rd_q, wr_q;
   logic [CNT_W-1:0]    cnt_q;

   logic                start_bad, issue_lf, issue_lt, room;
   logic                flush, push, pop;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH+1:0] head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign start_bad = (32'(ch_sel) >= NUM_CHANNELS) ||
                      (32'(tile_start) >= TILES_PER_MATRIX);
   assign issue_lf  = fetch_q == FETCH_W'(FETCHES_PER_TILE - 1);
   assign issue_lt  = issue_lf && (tile_q == last_tile_q);
   // Reads in flight are counted so the FIFO can always absorb their return.
   assign room      = (32'(cnt_q) + 32'(infl_q)) < FIFO_DEPTH;
   assign bram_en   = (state_q == S_ISSUE) && room;
   assign flush     = abort && (state_q != S_IDLE);

   assign addr = BASE_A + ADDR_WIDTH'(ch_q) * CH_A +
                 ADDR_WIDTH'(tile_q) * TILE_A + ADDR_WIDTH'(fetch_q) * ROW_A;
   assign bram_addr = bram_en ? addr : '0;

   assign head           = mem_q[rd_q];
   assign out_valid      = cnt_q != '0;
   assign out_data       = out_valid ? head[DATA_WIDTH-1:0] : '0;
   assign out_last_fetch = out_valid && head[DATA_WIDTH];
   assign out_last_tile  = out_valid && head[DATA_WIDTH+1];
   assign push           = infl_q && !flush;
   assign pop            = out_valid && out_ready;

   assign busy = (state_q == S_ISSUE) || (state_q == S_DRAIN);
   assign done = state_q == S_DONE;
   assign err  = err_q;

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      tile_d      = tile_q;
      last_tile_d = last_tile_q;
      fetch_d     = fetch_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && !start_bad) begin
               ch_d        = ch_sel;
               tile_d      = tile_start;
               last_tile_d = mode_all ? TILE_W'(TILES_PER_MATRIX - 1) : tile_start;
               fetch_d     = '0;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bram_en) begin
               if (issue_lf) begin
                  fetch_d = '0;
                  tile_d  = tile_q + TILE_W'(1);
               end else begin
                  fetch_d = fetch_q + FETCH_W'(1);
               end
               if (issue_lt) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!infl_q && (cnt_q == '0 || (cnt_q == CNT_W'(1) && pop)))
               state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ch_q        <= '0;
         tile_q      <= '0;
         last_tile_q <= '0;
         fetch_q     <= '0;
         infl_q      <= 1'b0;
         infl_tag_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         tile_q      <= tile_d;
         last_tile_q <= last_tile_d;
         fetch_q     <= fetch_d;
         infl_q      <= bram_en && !flush;
         infl_tag_q  <= {issue_lt, issue_lf};
         err_q       <= (state_q == S_IDLE) && start && start_bad;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= ptr_inc(wr_q);
         if (pop)  rd_q <= ptr_inc(rd_q);
         cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= {infl_tag_q, bram_dout};
   end

endmodule

// File: doc/qkv_tile_fetch_engine.md
# qkv_tile_fetch_engine

- Multi-channel, tile-oriented read sequencer for the Q/K/V weight BRAM in the attention datapath.
- For a selected channel (Q, K or V), it generates BRAM read addresses for one tile or a run of consecutive tiles, absorbs the 1-cycle BRAM read latency in an output FIFO, and streams the words downstream on a valid/ready handshake.
- It is the generalised successor of the single-channel fixed-tile fetch unit. It adds channel select, strided addressing, multi-tile runs, backpressure, abort and error reporting.

## Interface
Parameters:
- ADDR_WIDTH, 16, BRAM read address width
- DATA_WIDTH, 256, BRAM read word / stream width (32 × 8-bit elements)
- NUM_CHANNELS, 3, number of channels (0=Q, 1=K, 2=V)
- BASE_OFFSET, 0, address of channel 0 tile 0 fetch 0
- CH_STRIDE, 12288, address distance between channel bases
- FETCHES_PER_TILE, 32, words per tile
- TILES_PER_MATRIX, 24, tiles per channel (768/32)
- TILE_STRIDE, 32, address distance between tiles
- ROW_STRIDE, 1, address distance between fetches inside a tile
- FIFO_DEPTH, 4, output FIFO entries (≥3)

Ports:
- clk  in  1  clock; everything is rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  launch request; sampled only in IDLE
- ch_sel  in  clog2(NUM_CHANNELS)  channel for this run
- tile_start  in  clog2(TILES_PER_MATRIX)  first tile index
- mode_all  in  1  0 = fetch tile_start only; 1 = fetch tile_start..TILES_PER_MATRIX-1
- abort  in  1  terminate the current run
- bram_en  out  1  read enable
- bram_addr  out  ADDR_WIDTH  read address
- bram_dout  in  DATA_WIDTH  read data, valid on the cycle after bram_en
- out_valid  out  1  stream data valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_WIDTH  stream word
- out_last_fetch  out  1  word is the last of its tile
- out_last_tile  out  1  word is the final word of the run
- busy  out  1  high from the cycle after an accepted start until done or abort
- done  out  1  one-cycle pulse after the final word is accepted
- err  out  1  one-cycle pulse when start is rejected

## Operation
- **Address formula:** addr = BASE_OFFSET + ch×CH_STRIDE + tile×TILE_STRIDE + fetch×ROW_STRIDE. Computed modulo 2^ADDR_WIDTH (wraps silently).
- **States:**
  - IDLE
    - start with ch_sel ≥ NUM_CHANNELS or tile_start ≥ TILES_PER_MATRIX → err pulse next cycle, remain in IDLE.
    - Valid start → latch ch/tile/mode, clear counters, go to ISSUE.
  - ISSUE
    - Assert bram_en whenever fifo_count + inflight < FIFO_DEPTH. inflight is 1 if a read was issued last cycle.
    - The fetch counter advances on each issue. It wraps at FETCHES_PER_TILE and then increments the tile counter.
    - After the final read of the run is issued → go to DRAIN.
  - DRAIN
    - When the FIFO is empty, no read is in flight, and the final word has been accepted → go to DONE.
  - DONE
    - Pulse done for one cycle, deassert busy, return to IDLE.
- **Run length:**
  - mode_all=0: FETCHES_PER_TILE words.
  - mode_all=1: (TILES_PER_MATRIX − tile_start) × FETCHES_PER_TILE words.
- **Tag bits:** out_last_fetch and out_last_tile travel through the FIFO alongside the data.
- **Stream ordering:** strictly ascending issue order. A word is never dropped or duplicated under any out_ready pattern.
- **abort**
  - In any non-IDLE state: next cycle go to IDLE and flush the FIFO.
  - Any in-flight read return is discarded. No done pulse.
  - Abort has priority over a simultaneous final handshake.
  - abort in IDLE has no effect.
- **start while busy:** ignored; no err.
- **Simultaneous push and pop on the FIFO:** count is unchanged.

## Timing
- **Reset values:** all outputs 0, bram_addr 0, FIFO empty, state IDLE. rst during a run behaves like abort but also clears err/done.
- **Launch:** start accepted at edge E. The first bram_en is high in the cycle after E, and busy is high from that same cycle.
- **Read latency:** read issued in cycle N → bram_dout captured at the end of N+1 → out_valid no earlier than cycle N+2.
- **Throughput:** with out_ready held high, one word per cycle after the initial 3-cycle latency. Single tile: done pulses 1 cycle after the last handshake.
- **Backpressure:** out_data and the tag bits are held stable while out_valid=1 and out_ready=0. With out_ready low, at most FIFO_DEPTH reads are outstanding, then bram_en stays low.

## Test plan
- **Single tile, ready high.** Preload bram[a]=2a+2. Send start with ch=1, tile=2, mode_all=0.
  - Addresses must be 12352..12383 and the data 2a+2 in order.
  - out_last_fetch and out_last_tile both set on the 32nd word only.
  - done exactly 1 cycle after the last handshake.
- **Full run.** Send start with ch=2, tile=22, mode_all=1.
  - Expect 64 words, addresses 25280..25343.
  - out_last_fetch on words 32 and 64; out_last_tile on word 64.
- **Backpressure.** Drive random out_ready (about 30% high) on a ch=0 tile=0 run.
  - Sequence identical to the ready-high run.
  - bram_en never raised while fifo_count + inflight = 4.
  - Data held stable while stalled.
- **Errors.** Send start with ch_sel=3, then with tile_start=24.
  - err pulses once each; no bram_en; busy stays 0.
  - A subsequent start while busy is ignored.
- **Abort.** Assert abort after 10 accepted words.
  - Next cycle: busy=0, out_valid=0, no done.
  - A new run afterwards starts from its first address with a clean stream.
- **Reset mid-run.** Pulse rst in the middle of a DRAIN.
  - All outputs 0 on the next cycle.
  - A following run completes correctly.
